// File: rtl/ip_codma_bus_arbiter.sv
// Read/write bus arbiter for the CODMA engine: round-robin between the read and write machines, with a request (ASK) and ownership (OWN) phase.
// Optional timeout watchdog is enabled by defining CODMA_ARB_TIMEOUT_EN.
module ip_codma_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  input  logic [3:0]  rd_size_i,
  input  logic        rd_done_i,
  output logic        rd_gnt_o,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [3:0]  wr_size_i,
  input  logic        wr_done_i,
  output logic        wr_gnt_o,
  input  logic        abort_i,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_size_o,
  input  logic        bus_grant_i,
  output logic        arb_error_o
);

  localparam logic [3:0] IDLE_SIZE = 4'd9;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_RD_ASK,
    ARB_RD_OWN,
    ARB_WR_ASK,
    ARB_WR_OWN,
    ARB_ERROR
  } arb_state_e;

  arb_state_e  state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic        rd_gnt_q, rd_gnt_d;
  logic        wr_gnt_q, wr_gnt_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_size_q, bus_size_d;
  logic        timeout_hit;
  logic        busy_q;

  assign busy_q = (state_q == ARB_RD_ASK) || (state_q == ARB_RD_OWN) ||
                  (state_q == ARB_WR_ASK) || (state_q == ARB_WR_OWN);

`ifdef CODMA_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout_hit = busy_q && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (busy_q && (state_d != ARB_IDLE) && (state_d != ARB_ERROR)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign err_d = (state_d == ARB_ERROR);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_error_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign arb_error_o = 1'b0;
`endif

  // Priority: abort, then timeout, then the normal grant/done/request flow.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    if (abort_i) begin
      state_d = ARB_IDLE;
    end else if (timeout_hit) begin
      state_d = ARB_ERROR;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (rd_req_i && wr_req_i) state_d = last_wr_q ? ARB_RD_ASK : ARB_WR_ASK;
          else if (rd_req_i)        state_d = ARB_RD_ASK;
          else if (wr_req_i)        state_d = ARB_WR_ASK;
        end
        ARB_RD_ASK: begin
          if (bus_grant_i)    state_d = ARB_RD_OWN;
          else if (!rd_req_i) state_d = ARB_IDLE;
        end
        ARB_RD_OWN: begin
          if (rd_done_i) begin
            state_d   = ARB_IDLE;
            last_wr_d = 1'b0;
          end
        end
        ARB_WR_ASK: begin
          if (bus_grant_i)    state_d = ARB_WR_OWN;
          else if (!wr_req_i) state_d = ARB_IDLE;
        end
        ARB_WR_OWN: begin
          if (wr_done_i) begin
            state_d   = ARB_IDLE;
            last_wr_d = 1'b1;
          end
        end
        ARB_ERROR: state_d = ARB_ERROR;
        default:   state_d = ARB_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    bus_read_d  = (state_d == ARB_RD_ASK);
    bus_write_d = (state_d == ARB_WR_ASK);
    rd_gnt_d    = (state_d == ARB_RD_OWN);
    wr_gnt_d    = (state_d == ARB_WR_OWN);
    bus_addr_d  = '0;
    bus_size_d  = IDLE_SIZE;
    if (state_d == ARB_RD_ASK && state_q != ARB_RD_ASK) begin
      bus_addr_d = rd_addr_i;
      bus_size_d = rd_size_i;
    end else if (state_d == ARB_WR_ASK && state_q != ARB_WR_ASK) begin
      bus_addr_d = wr_addr_i;
      bus_size_d = wr_size_i;
    end else if (state_d == ARB_RD_ASK || state_d == ARB_RD_OWN ||
                 state_d == ARB_WR_ASK || state_d == ARB_WR_OWN) begin
      bus_addr_d = bus_addr_q;
      bus_size_d = bus_size_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ARB_IDLE;
      last_wr_q   <= 1'b1;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_size_q  <= IDLE_SIZE;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      rd_gnt_q    <= rd_gnt_d;
      wr_gnt_q    <= wr_gnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_size_q  <= bus_size_d;
    end
  end

  assign bus_read_o  = bus_read_q;
  assign bus_write_o = bus_write_q;
  assign rd_gnt_o    = rd_gnt_q;
  assign wr_gnt_o    = wr_gnt_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_size_o  = bus_size_q;

endmodule
